// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: refills a 16-byte cache block, one word per cycle, from a
// single-cycle memory. It also commits write-through stores to that memory.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no memory traffic; arbitrates miss (first) against store
// FILL  | one word per cycle, word cnt; tag/done pulse on word 7
// WRITE | one memory write of the latched store, wr_ack pulse
//
// A store that is still pending on the last fill word goes straight to
// WRITE. This keeps it serviced after the fill with no idle bubble.
// A miss is never chained that way: the cache holds miss_detected until it
// sees fill_done, so sampling it on the last word would start a bogus refill.
module cache_fill_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_detected,
  input  logic [15:0] miss_address,
  input  logic        wr_req,
  input  logic [15:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic [15:0] mem_data_out,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic        cache_data_we,
  output logic [2:0]  cache_word_idx,
  output logic [15:0] cache_data,
  output logic        tag_we,
  output logic        fill_done,
  output logic        wr_ack,
  output logic        fsm_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [11:0] blk_q, blk_d;
  logic [14:0] waddr_q, waddr_d;
  logic [15:0] wdata_q, wdata_d;

  // Next-state, word counter and request latching.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (miss_detected) begin
          blk_d   = miss_address[15:4];
          cnt_d   = 3'd0;
          state_d = FILL;
        end else if (wr_req) begin
          waddr_d = wr_addr[15:1];
          wdata_d = wr_data;
          state_d = WRITE;
        end
      end
      FILL: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          if (wr_req) begin
            waddr_d = wr_addr[15:1];
            wdata_d = wr_data;
            state_d = WRITE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      blk_q   <= 12'd0;
      waddr_q <= 15'd0;
      wdata_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  // Outputs decode only the registered state. They are forced low while rst
  // is high, so a reset raised mid-fill or mid-write has no effect on memory.
  always_comb begin
    mem_addr       = 16'd0;
    mem_data_in    = 16'd0;
    mem_enable     = 1'b0;
    mem_wr         = 1'b0;
    cache_data_we  = 1'b0;
    cache_word_idx = 3'd0;
    cache_data     = 16'd0;
    tag_we         = 1'b0;
    fill_done      = 1'b0;
    wr_ack         = 1'b0;
    fsm_busy       = 1'b0;
    if (!rst) begin
      case (state_q)
        FILL: begin
          fsm_busy       = 1'b1;
          mem_enable     = 1'b1;
          mem_addr       = {blk_q, cnt_q, 1'b0};
          cache_data_we  = 1'b1;
          cache_word_idx = cnt_q;
          cache_data     = mem_data_out;
          tag_we         = (cnt_q == 3'd7);
          fill_done      = (cnt_q == 3'd7);
        end
        WRITE: begin
          fsm_busy    = 1'b1;
          mem_enable  = 1'b1;
          mem_wr      = 1'b1;
          mem_addr    = {waddr_q, 1'b0};
          mem_data_in = wdata_q;
          wr_ack      = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
